// File: rtl/display_pkg.sv
// Shared display definitions for the queue sprite animator and its colour stage.
package display_pkg;

  // Pose codes the colour stage understands on animate_state[0]
  localparam logic QUEUE_LEFT  = 1'b0;
  localparam logic QUEUE_RIGHT = 1'b1;

  // Width of the animate_state bus handed to the colour stage
  localparam int ANIM_W = 4;

  // Animator control states
  typedef enum logic [1:0] {
    IDLE,
    WAVE,
    REST,
    DONE
  } anim_state_t;

  // Counter width for a terminal count n, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/queue_animator_tick_counter.sv
// Free-running tick counter that wraps at a terminal count and pulses done on the last tick.
module tick_counter
  import display_pkg::*;
#(
  parameter int TERMINAL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int W = cnt_width(TERMINAL);
  localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

  logic [W-1:0] count;

  assign done = en && !clear && (count == LAST);

  // Count while enabled, restart at zero on clear or after the terminal tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || done) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/queue_animator.sv
// Queue sprite animator: waves LEFT/RIGHT in bursts, rests, and freezes on rescue.
// Pose changes reach animate_state only on frame_sync so a frame never tears.
module queue_animator
  import display_pkg::*;
#(
  parameter logic [9:0] POS_X      = 10'd200,
  parameter logic [8:0] POS_Y      = 9'd40,
  parameter int         FLIP_TICKS = 12_500_000,
  parameter int         WAVE_FLIPS = 6,
  parameter int         REST_TICKS = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rescued,
  input  logic              frame_sync,
  output logic [9:0]        posx,
  output logic [8:0]        posy,
  output logic [ANIM_W-1:0] animate_state
);

  localparam int FW = cnt_width(WAVE_FLIPS);
  localparam logic [FW-1:0] FLIP_LAST = FW'(WAVE_FLIPS - 1);

  anim_state_t   state;
  logic [FW-1:0] flip_cnt;
  logic          pending;
  logic          flip_done;
  logic          rest_done;
  logic          override;

  // Leaving IDLE/WAVE/REST for a priority reason must also zero the timers
  assign override = !enable || rescued;

  tick_counter #(.TERMINAL(FLIP_TICKS)) u_flip_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (override || (state != WAVE)),
    .en    (state == WAVE),
    .done  (flip_done)
  );

  tick_counter #(.TERMINAL(REST_TICKS)) u_rest_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (override || (state != REST)),
    .en    (state == REST),
    .done  (rest_done)
  );

  // Control FSM with registered pose, burst count, display latch and fixed position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      flip_cnt      <= '0;
      pending       <= QUEUE_LEFT;
      animate_state <= '0;
      posx          <= POS_X;
      posy          <= POS_Y;
    end else begin
      posx <= POS_X;
      posy <= POS_Y;

      if (frame_sync) begin
        animate_state <= {{(ANIM_W-1){1'b0}}, pending};
      end

      if (!enable) begin
        state    <= IDLE;
        flip_cnt <= '0;
        pending  <= QUEUE_LEFT;
      end else if (rescued) begin
        state   <= DONE;
        pending <= QUEUE_RIGHT;
      end else begin
        case (state)
          IDLE: begin
            state    <= WAVE;
            flip_cnt <= '0;
            pending  <= QUEUE_LEFT;
          end
          WAVE: begin
            if (flip_done) begin
              if (flip_cnt == FLIP_LAST) begin
                state    <= REST;
                flip_cnt <= '0;
                pending  <= QUEUE_LEFT;
              end else begin
                flip_cnt <= flip_cnt + FW'(1);
                pending  <= ~pending;
              end
            end
          end
          REST: begin
            pending <= QUEUE_LEFT;
            if (rest_done) begin
              state <= WAVE;
            end
          end
          DONE: begin
            pending <= QUEUE_RIGHT;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_queue_animator.sv
// Self-checking bench for queue_animator with short timing parameters.
module tb_queue_animator;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       rescued;
  logic       frame_sync;
  logic [9:0] posx;
  logic [8:0] posy;
  logic [3:0] animate_state;

  int errors;
  int checks;

  typedef struct {
    int         cycles;
    logic       en;
    logic       resc;
    logic       fs;
    logic [3:0] exp_anim;
    string      name;
  } vec_t;

  vec_t vecs[10];

  queue_animator #(
    .POS_X      (10'd200),
    .POS_Y      (9'd40),
    .FLIP_TICKS (4),
    .WAVE_FLIPS (3),
    .REST_TICKS (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .rescued       (rescued),
    .frame_sync    (frame_sync),
    .posx          (posx),
    .posy          (posy),
    .animate_state (animate_state)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic en, input logic resc, input logic fs, input int n);
    enable     = en;
    rescued    = resc;
    frame_sync = fs;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_anim);
    checks++;
    if (animate_state !== exp_anim) begin
      errors++;
      $display("[TB] FAIL %s animate_state: got %0d expected %0d", name, animate_state, exp_anim);
    end
    checks++;
    if (posx !== 10'd200) begin
      errors++;
      $display("[TB] FAIL %s posx: got %0d expected 200", name, posx);
    end
    checks++;
    if (posy !== 9'd40) begin
      errors++;
      $display("[TB] FAIL %s posy: got %0d expected 40", name, posy);
    end
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    enable     = 1'b0;
    rescued    = 1'b0;
    frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 4'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Main waving scenario: frame_sync every cycle, enable from cycle 0
    vecs[0] = '{1, 1'b1, 1'b0, 1'b1, 4'd0, "c0_start"};
    vecs[1] = '{4, 1'b1, 1'b0, 1'b1, 4'd0, "c4_flip1"};
    vecs[2] = '{1, 1'b1, 1'b0, 1'b1, 4'd1, "c5_right"};
    vecs[3] = '{3, 1'b1, 1'b0, 1'b1, 4'd1, "c8_flip2"};
    vecs[4] = '{1, 1'b1, 1'b0, 1'b1, 4'd0, "c9_left"};
    vecs[5] = '{3, 1'b1, 1'b0, 1'b1, 4'd0, "c12_flip3"};
    vecs[6] = '{1, 1'b1, 1'b0, 1'b1, 4'd0, "c13_rest"};
    vecs[7] = '{9, 1'b1, 1'b0, 1'b1, 4'd0, "c22_rewave"};
    vecs[8] = '{4, 1'b1, 1'b0, 1'b1, 4'd0, "c26_flip"};
    vecs[9] = '{1, 1'b1, 1'b0, 1'b1, 4'd1, "c27_right"};

    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].en, vecs[i].resc, vecs[i].fs, vecs[i].cycles);
      checkOutput(vecs[i].name, vecs[i].exp_anim);
    end

    // Sparse frame_sync on cycles 0, 7, 14
    doReset();
    for (int c = 0; c <= 14; c++) begin
      applyStimulus(1'b1, 1'b0, (c % 7) == 0, 1);
      if (c == 6)  checkOutput("sync7_before", 4'd0);
      if (c == 7)  checkOutput("sync7_right", 4'd1);
      if (c == 13) checkOutput("sync14_hold", 4'd1);
      if (c == 14) checkOutput("sync14_left", 4'd0);
    end

    // Rescue arriving on the same edge as the first flip
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 4);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    checkOutput("rescue_edge", 4'd0);
    checks++;
    if (dut.flip_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL rescue_flip_cnt: got %0d expected 0", dut.flip_cnt);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("rescue_shown", 4'd1);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1);
      checkOutput("rescue_hold", 4'd1);
    end

    // Enable dropped while showing RIGHT, then re-enabled
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 6);
    checkOutput("drop_right", 4'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("drop_edge", 4'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("drop_left", 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5);
    checkOutput("reenable_flip", 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("reenable_right", 4'd1);

    // Asynchronous reset between clock edges mid-burst
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 6);
    checkOutput("pre_async", 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_now", 4'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1);
      checkOutput("async_held", 4'd0);
    end
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 5);
    checkOutput("async_release", 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("async_rewave", 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
